// File: rtl/norm2_pkg.sv
// Shared defaults and types for the norm2 feeder: array geometry, widths and FSM states.
package norm2_pkg;

    localparam int unsigned N_DEF       = 1000;
    localparam int unsigned AW_DEF      = 10;
    localparam int unsigned DW_DEF      = 27;
    localparam int unsigned RW_DEF      = 64;
    localparam int unsigned CW_DEF      = 32;
    localparam int unsigned TIMEOUT_DEF = 4096;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ZFILL,
        FLUSH,
        START,
        RUN,
        DONE
    } state_e;

    typedef logic signed [DW_DEF-1:0] sample_t;
    typedef logic signed [RW_DEF-1:0] acc_t;

endpackage

// File: rtl/norm2_if.sv
// Sample stream, result stream and kernel array-control signals of the norm2 feeder.
interface norm2_if #(
    parameter int unsigned AW = norm2_pkg::AW_DEF,
    parameter int unsigned DW = norm2_pkg::DW_DEF,
    parameter int unsigned RW = norm2_pkg::RW_DEF,
    parameter int unsigned CW = norm2_pkg::CW_DEF
);
    logic                 s_valid;
    logic                 s_ready;
    logic signed [DW-1:0] s_data;
    logic                 s_last;

    logic                 m_valid;
    logic                 m_ready;
    logic signed [RW-1:0] m_result;
    logic [CW-1:0]        m_cycles;
    logic                 m_short;
    logic                 m_timeout;

    logic                 k_r_enable;
    logic                 k_controlArr;
    logic [AW-1:0]        k_init_i;
    logic signed [RW-1:0] k_init_acc;
    logic                 k_wen;
    logic [AW-1:0]        k_addr;
    logic signed [DW-1:0] k_wdata;
    logic                 k_w_enable;
    logic signed [RW-1:0] k_result;

    modport master (
        input  s_valid, s_data, s_last, m_ready, k_w_enable, k_result,
        output s_ready, m_valid, m_result, m_cycles, m_short, m_timeout,
        output k_r_enable, k_controlArr, k_init_i, k_init_acc,
        output k_wen, k_addr, k_wdata
    );

    modport slave (
        output s_valid, s_data, s_last, m_ready, k_w_enable, k_result,
        input  s_ready, m_valid, m_result, m_cycles, m_short, m_timeout,
        input  k_r_enable, k_controlArr, k_init_i, k_init_acc,
        input  k_wen, k_addr, k_wdata
    );

endinterface

// File: rtl/norm2_wr_port.sv
// Registered driver for the kernel array write port; a write decided now appears next cycle.
module norm2_wr_port
    import norm2_pkg::*;
#(
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned DW = DW_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_req_i,
    input  logic [AW-1:0]        addr_i,
    input  logic signed [DW-1:0] data_i,
    output logic                 wen_o,
    output logic [AW-1:0]        addr_o,
    output logic signed [DW-1:0] data_o
);
    logic                 wen_q;
    logic [AW-1:0]        addr_q;
    logic signed [DW-1:0] data_q;

    // Address and data hold their last value between writes; only wen drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wen_q  <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            wen_q <= wr_req_i;
            if (wr_req_i) begin
                addr_q <= addr_i;
                data_q <= data_i;
            end
        end
    end

    assign wen_o  = wen_q;
    assign addr_o = addr_q;
    assign data_o = data_q;

endmodule

// File: rtl/norm2_feeder.sv
// Loads a zero-padded sample frame into the norm2 kernel array, runs the kernel and
// returns its sum of squares with cycle count and short/timeout flags.
module norm2_feeder
    import norm2_pkg::*;
#(
    parameter int unsigned N       = N_DEF,
    parameter int unsigned AW      = AW_DEF,
    parameter int unsigned DW      = DW_DEF,
    parameter int unsigned RW      = RW_DEF,
    parameter int unsigned CW      = CW_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic    clk,
    input  logic    rst_n,
    norm2_if.master bus
);
    localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);
    localparam logic [CW-1:0] TMO_CNT   = CW'(TIMEOUT);

    state_e               state_q, state_d;
    logic [AW-1:0]        count_q, count_d;
    logic [CW-1:0]        cyc_q, cyc_d, cyc_inc;
    logic signed [RW-1:0] res_q, res_d;
    logic [CW-1:0]        cycles_q, cycles_d;
    logic                 short_q, short_d;
    logic                 tmo_q, tmo_d;
    logic                 wr_req;
    logic [AW-1:0]        wr_addr;
    logic signed [DW-1:0] wr_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            cyc_q    <= '0;
            res_q    <= '0;
            cycles_q <= '0;
            short_q  <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            cyc_q    <= cyc_d;
            res_q    <= res_d;
            cycles_q <= cycles_d;
            short_q  <= short_d;
            tmo_q    <= tmo_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        cyc_d    = cyc_q;
        res_d    = res_q;
        cycles_d = cycles_q;
        short_d  = short_q;
        tmo_d    = tmo_q;
        wr_req   = 1'b0;
        wr_addr  = count_q;
        wr_data  = '0;
        cyc_inc  = (cyc_q == '1) ? cyc_q : cyc_q + 1'b1;

        unique case (state_q)
            IDLE: begin
                count_d = '0;
                state_d = LOAD;
            end
            LOAD: begin
                if (bus.s_valid) begin
                    wr_req  = 1'b1;
                    wr_data = bus.s_data;
                    count_d = count_q + 1'b1;
                    // A full frame ends on count alone, so s_last on sample N-1 is just a sample.
                    if (count_q == LAST_ADDR) begin
                        state_d = FLUSH;
                        short_d = 1'b0;
                    end else if (bus.s_last) begin
                        state_d = ZFILL;
                        short_d = 1'b1;
                    end
                end
            end
            ZFILL: begin
                wr_req  = 1'b1;
                count_d = count_q + 1'b1;
                if (count_q == LAST_ADDR) state_d = FLUSH;
            end
            FLUSH: state_d = START;
            START: begin
                cyc_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                cyc_d = cyc_inc;
                // Kernel completion takes priority over a timeout in the same cycle.
                if (bus.k_w_enable) begin
                    res_d    = bus.k_result;
                    cycles_d = cyc_inc;
                    state_d  = DONE;
                end else if (cyc_inc == TMO_CNT) begin
                    res_d    = '0;
                    cycles_d = TMO_CNT;
                    tmo_d    = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (bus.m_ready) begin
                    short_d = 1'b0;
                    tmo_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    norm2_wr_port #(
        .AW (AW),
        .DW (DW)
    ) u_wr_port (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_req_i (wr_req),
        .addr_i   (wr_addr),
        .data_i   (wr_data),
        .wen_o    (bus.k_wen),
        .addr_o   (bus.k_addr),
        .data_o   (bus.k_wdata)
    );

    assign bus.s_ready      = (state_q == LOAD);
    assign bus.m_valid      = (state_q == DONE);
    assign bus.m_result     = res_q;
    assign bus.m_cycles     = cycles_q;
    assign bus.m_short      = short_q;
    assign bus.m_timeout    = tmo_q;
    assign bus.k_r_enable   = (state_q != RUN);
    assign bus.k_controlArr = (state_q inside {IDLE, LOAD, ZFILL, FLUSH});
    assign bus.k_init_i     = '0;
    assign bus.k_init_acc   = '0;

endmodule

// File: tb/tb_norm2_feeder.sv
// Directed bench for norm2_feeder with a behavioural kernel model and a result scoreboard.
module tb_norm2_feeder;
    import norm2_pkg::*;

    localparam int NS  = 1000;
    localparam int LAT = 10;
    localparam int TMO = 64;

    typedef struct {
        logic signed [63:0] res;
        logic [31:0]        cyc;
        logic               sh;
        logic               to;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    norm2_if bus ();

    norm2_feeder #(
        .TIMEOUT (TMO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;
    exp_t sbq[$];

    logic signed [26:0] exp_arr [NS];
    logic signed [26:0] kmem    [NS];
    int tot_w = 0, tot_z = 0, tot_run = 0, tot_bad = 0;
    int kcnt = 0;
    logic kstub = 1'b0;
    logic kw = 1'b0;
    logic signed [63:0] kres = '0;

    assign bus.k_w_enable = kw;
    assign bus.k_result   = kres;

    function automatic logic signed [63:0] ssq_mem();
        logic signed [63:0] s = '0;
        logic signed [63:0] v;
        for (int i = 0; i < NS; i++) begin
            v = kmem[i];
            s = s + v * v;
        end
        return s;
    endfunction

    function automatic logic signed [63:0] ssq_exp();
        logic signed [63:0] s = '0;
        logic signed [63:0] v;
        for (int i = 0; i < NS; i++) begin
            v = exp_arr[i];
            s = s + v * v;
        end
        return s;
    endfunction

    // Kernel model: captures array writes, sums on START, raises w_enable on RUN cycle LAT.
    always @(posedge clk) begin
        if (bus.k_wen) begin
            if (int'(bus.k_addr) < NS) kmem[bus.k_addr] <= bus.k_wdata;
            else tot_bad <= tot_bad + 1;
            tot_w <= tot_w + 1;
            if (bus.k_wdata == 0) tot_z <= tot_z + 1;
        end
        if (!bus.k_r_enable) tot_run <= tot_run + 1;
        if (!bus.k_controlArr && bus.k_r_enable) kres <= ssq_mem();
        if (bus.k_r_enable) begin
            kcnt <= 0;
            kw   <= 1'b0;
        end else begin
            kcnt <= kcnt + 1;
            kw   <= !kstub && (kcnt + 1 >= LAT - 1);
        end
    end

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic reset_chk(input string tag);
        chk({tag, "_s_ready"}, bus.s_ready, 0);
        chk({tag, "_m_valid"}, bus.m_valid, 0);
        chk({tag, "_k_r_enable"}, bus.k_r_enable, 1);
        chk({tag, "_k_controlArr"}, bus.k_controlArr, 1);
        chk({tag, "_k_wen"}, bus.k_wen, 0);
        chk({tag, "_k_addr"}, bus.k_addr, 0);
        chk({tag, "_k_wdata"}, bus.k_wdata, 0);
        chk({tag, "_m_result"}, bus.m_result, 0);
        chk({tag, "_m_cycles"}, bus.m_cycles, 0);
        chk({tag, "_m_short"}, bus.m_short, 0);
        chk({tag, "_m_timeout"}, bus.m_timeout, 0);
    endtask

    task automatic send_sample(input logic signed [26:0] d, input logic last);
        int n = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_last  = last;
        while (1) begin
            @(negedge clk);
            if (bus.s_ready === 1'b1) break;
            n++;
            if (n > 4000) begin
                chk("s_ready_wait", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic send_frame(input int len, input logic last_flag);
        for (int i = 0; i < len; i++)
            send_sample(exp_arr[i], last_flag && (i == len - 1));
    endtask

    task automatic wait_mvalid(input string tag);
        int n = 0;
        while (1) begin
            @(negedge clk);
            if (bus.m_valid === 1'b1) break;
            n++;
            if (n > 4000) begin
                chk({tag, "_m_valid_wait"}, 0, 1);
                break;
            end
        end
    endtask

    task automatic pop_exp(output exp_t e);
        if (sbq.size() == 0) begin
            chk("scoreboard_empty", 0, 1);
            e = '{res: '0, cyc: '0, sh: 1'b0, to: 1'b0};
        end else begin
            e = sbq.pop_front();
        end
    endtask

    // Holds m_ready low for `hold` cycles checking stability, then compares and accepts.
    task automatic check_result(input string tag, input exp_t e, input int hold);
        logic signed [63:0] r0;
        logic [31:0] c0;
        logic s0, t0;
        int viol = 0;
        r0 = bus.m_result; c0 = bus.m_cycles; s0 = bus.m_short; t0 = bus.m_timeout;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (bus.m_valid !== 1'b1 || bus.s_ready !== 1'b0 || bus.m_result !== r0 ||
                bus.m_cycles !== c0 || bus.m_short !== s0 || bus.m_timeout !== t0)
                viol++;
        end
        if (hold > 0) chk({tag, "_stall_stable"}, viol, 0);
        chk({tag, "_result"}, bus.m_result, e.res);
        chk({tag, "_cycles"}, bus.m_cycles, e.cyc);
        chk({tag, "_short"}, bus.m_short, e.sh);
        chk({tag, "_timeout"}, bus.m_timeout, e.to);
        bus.m_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.m_ready = 1'b0;
    endtask

    task automatic mem_chk(input string tag);
        int m = 0;
        for (int i = 0; i < NS; i++) if (kmem[i] !== exp_arr[i]) m++;
        chk({tag, "_array"}, m, 0);
    endtask

    task automatic push_exp(input logic [31:0] cyc, input logic sh, input logic to,
                            input logic signed [63:0] res);
        exp_t e;
        e.res = res; e.cyc = cyc; e.sh = sh; e.to = to;
        sbq.push_back(e);
    endtask

    initial begin
        exp_t e;
        int w0, z0, r0, b0, n;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b0;
        #12;
        reset_chk("por");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Full frame of 3s, m_valid must be held until accepted.
        for (int i = 0; i < NS; i++) exp_arr[i] = 27'sd3;
        push_exp(LAT, 1'b0, 1'b0, ssq_exp());
        w0 = tot_w; z0 = tot_z;
        send_frame(NS, 1'b1);
        wait_mvalid("A");
        chk("A_writes", tot_w - w0, NS);
        chk("A_zero_writes", tot_z - z0, 0);
        mem_chk("A");
        pop_exp(e);
        check_result("A", e, 5);
        @(negedge clk);
        chk("A_m_valid_drop", bus.m_valid, 0);

        // Signed ramp k-500, then a 20-cycle stall with the next frame's first sample offered.
        for (int i = 0; i < NS; i++) exp_arr[i] = 27'(i - 500);
        push_exp(LAT, 1'b0, 1'b0, ssq_exp());
        chk("B_expected_sum", ssq_exp(), 64'sd83333500);
        send_frame(NS, 1'b1);
        bus.s_valid = 1'b1;
        bus.s_data  = 27'sd1;
        bus.s_last  = 1'b0;
        wait_mvalid("B");
        mem_chk("B");
        chk("B_neg_sample", kmem[0], -500);
        pop_exp(e);
        for (int i = 0; i < NS; i++) exp_arr[i] = '0;
        exp_arr[0] = 27'sd1; exp_arr[1] = 27'sd2; exp_arr[2] = 27'sd3;
        w0 = tot_w; z0 = tot_z; b0 = tot_bad;
        check_result("B", e, 20);
        @(negedge clk);
        chk("B_idle_s_ready", bus.s_ready, 0);
        chk("B_idle_m_valid", bus.m_valid, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("B_load_s_ready", bus.s_ready, 1);
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;

        // Short frame 1,2,3: the remaining 997 entries are zero-filled.
        push_exp(LAT, 1'b1, 1'b0, ssq_exp());
        send_sample(27'sd2, 1'b0);
        send_sample(27'sd3, 1'b1);
        @(negedge clk);
        chk("C_zfill_s_ready", bus.s_ready, 0);
        wait_mvalid("C");
        chk("C_writes", tot_w - w0, NS);
        chk("C_zero_writes", tot_z - z0, NS - 3);
        chk("C_bad_addr", tot_bad - b0, 0);
        mem_chk("C");
        pop_exp(e);
        check_result("C", e, 0);

        // Kernel never completes: abort after TMO RUN cycles.
        kstub = 1'b1;
        push_exp(TMO, 1'b1, 1'b1, 64'sd0);
        r0 = tot_run;
        send_sample(27'sd4, 1'b1);
        wait_mvalid("T");
        chk("T_run_cycles", tot_run - r0, TMO);
        chk("T_k_r_enable", bus.k_r_enable, 1);
        pop_exp(e);
        check_result("T", e, 2);
        kstub = 1'b0;

        // Reset mid-LOAD after 500 samples.
        for (int i = 0; i < 500; i++) send_sample(27'sd7, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        reset_chk("rstL");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset mid-RUN.
        for (int i = 0; i < NS; i++) send_sample(27'sd5, 1'b0);
        n = 0;
        while (bus.k_r_enable !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("R_reached_run", bus.k_r_enable, 0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        reset_chk("rstR");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Clean full frame of 2s after the aborted runs.
        for (int i = 0; i < NS; i++) exp_arr[i] = 27'sd2;
        push_exp(LAT, 1'b0, 1'b0, 64'sd4000);
        send_frame(NS, 1'b1);
        wait_mvalid("D");
        mem_chk("D");
        pop_exp(e);
        check_result("D", e, 0);
        chk("sb_drained", sbq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
